// File: rtl/scoreboard_clock_if.sv
// Scoreboard clock bus: control inputs plus counter, status and segment outputs.
// The master drives the controls; the slave (the clock core) drives the displays.
interface scoreboard_clock_if;
    logic        tick;
    logic        run;
    logic        next_qtr;
    logic        possession;
    logic        view_sel;
    logic [12:0] game_secs;
    logic [6:0]  play_secs;
    logic [2:0]  quarter;
    logic [1:0]  state;
    logic        qtr_end_p;
    logic        play_exp_p;
    logic [6:0]  seg3;
    logic [6:0]  seg2;
    logic [6:0]  seg1;
    logic [6:0]  seg0;

    modport master (
        output tick, run, next_qtr, possession, view_sel,
        input  game_secs, play_secs, quarter, state, qtr_end_p, play_exp_p,
        input  seg3, seg2, seg1, seg0
    );

    modport slave (
        input  tick, run, next_qtr, possession, view_sel,
        output game_secs, play_secs, quarter, state, qtr_end_p, play_exp_p,
        output seg3, seg2, seg1, seg0
    );
endinterface

// File: rtl/scoreboard_clock.sv
// Game/quarter clock with optional play clock and 4-digit 7-segment display.
// Define PLAY_CLOCK_EN to build the play clock, possession reload and play view.
module scoreboard_clock #(
    parameter int GAME_SECS    = 600,
    parameter int PLAY_SECS    = 15,
    parameter int NUM_QUARTERS = 4
) (
    input  logic              clk,
    input  logic              reset,
    scoreboard_clock_if.slave sb
);
    typedef enum logic [1:0] {
        ST_STOPPED = 2'b00,
        ST_RUNNING = 2'b01,
        ST_QTR_END = 2'b10,
        ST_FINAL   = 2'b11
    } state_t;

    state_t      state_reg, state_next;
    logic [12:0] game_reg, game_next;
    logic [2:0]  quarter_reg, quarter_next;
    logic        qtr_end_p_reg, qtr_end_p_next;
    logic        qtr_reload;
    logic        tick_run;
    logic [6:0]  play_val;
    logic        view_play;

    // Ticks only count when the pre-edge state is RUNNING.
    assign tick_run = sb.tick && (state_reg == ST_RUNNING);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_STOPPED;
            game_reg      <= 13'(GAME_SECS);
            quarter_reg   <= 3'd1;
            qtr_end_p_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            game_reg      <= game_next;
            quarter_reg   <= quarter_next;
            qtr_end_p_reg <= qtr_end_p_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        game_next      = game_reg;
        quarter_next   = quarter_reg;
        qtr_end_p_next = 1'b0;
        qtr_reload     = 1'b0;
        case (state_reg)
            ST_STOPPED: begin
                if (sb.run) state_next = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (!sb.run) state_next = ST_STOPPED;
                // Expiry outranks a simultaneous stop request.
                if (tick_run && game_reg != 13'd0) begin
                    game_next = game_reg - 13'd1;
                    if (game_reg == 13'd1) begin
                        state_next     = ST_QTR_END;
                        qtr_end_p_next = 1'b1;
                    end
                end
            end
            ST_QTR_END: begin
                if (sb.next_qtr) begin
                    if (quarter_reg < 3'(NUM_QUARTERS)) begin
                        quarter_next = quarter_reg + 3'd1;
                        game_next    = 13'(GAME_SECS);
                        state_next   = ST_STOPPED;
                        qtr_reload   = 1'b1;
                    end else begin
                        state_next = ST_FINAL;
                    end
                end
            end
            default: ;
        endcase
    end

`ifdef PLAY_CLOCK_EN
    logic [6:0] play_reg, play_next;
    logic       play_exp_p_reg, play_exp_p_next;
    logic       poss_prev_reg;
    logic       poss_rise;

    assign poss_rise = sb.possession && !poss_prev_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            play_reg       <= 7'(PLAY_SECS);
            play_exp_p_reg <= 1'b0;
            poss_prev_reg  <= 1'b0;
        end else begin
            play_reg       <= play_next;
            play_exp_p_reg <= play_exp_p_next;
            poss_prev_reg  <= sb.possession;
        end
    end

    // A reload beats a same-cycle decrement and so also hides its expiry pulse.
    always_comb begin
        play_next       = play_reg;
        play_exp_p_next = 1'b0;
        if (state_reg != ST_FINAL && (poss_rise || qtr_reload)) begin
            play_next = 7'(PLAY_SECS);
        end else if (tick_run && play_reg != 7'd0) begin
            play_next       = play_reg - 7'd1;
            play_exp_p_next = (play_reg == 7'd1);
        end
    end

    assign play_val      = play_reg;
    assign view_play     = sb.view_sel;
    assign sb.play_exp_p = play_exp_p_reg;
`else
    logic unused_play;
    assign unused_play   = &{1'b0, sb.possession, sb.view_sel, tick_run, qtr_reload};
    assign play_val      = 7'd0;
    assign view_play     = 1'b0;
    assign sb.play_exp_p = 1'b0;
`endif

    assign sb.play_secs = play_val;
    assign sb.game_secs = game_reg;
    assign sb.quarter   = quarter_reg;
    assign sb.state     = state_reg;
    assign sb.qtr_end_p = qtr_end_p_reg;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0011000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    logic [6:0] minutes;
    logic [5:0] seconds;
    logic [3:0] digit [4];
    logic [3:0] blank_mask;
    logic [6:0] seg_arr [4];

    always_comb begin
        minutes = 7'(game_reg / 13'd60);
        seconds = 6'(game_reg - 13'(minutes) * 13'd60);
        if (view_play) begin
            digit[3]   = 4'd0;
            digit[2]   = 4'd0;
            digit[1]   = 4'(play_val / 7'd10);
            digit[0]   = 4'(play_val % 7'd10);
            blank_mask = 4'b1100;
        end else begin
            digit[3]   = 4'(minutes / 7'd10);
            digit[2]   = 4'(minutes % 7'd10);
            digit[1]   = 4'(seconds / 6'd10);
            digit[0]   = 4'(seconds % 6'd10);
            blank_mask = 4'b0000;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_seg
        assign seg_arr[gi] = blank_mask[gi] ? 7'b1111111 : seg_decode(digit[gi]);
    end

    assign sb.seg3 = seg_arr[3];
    assign sb.seg2 = seg_arr[2];
    assign sb.seg1 = seg_arr[1];
    assign sb.seg0 = seg_arr[0];
endmodule
